// File: rtl/data_types_result_acc.sv
// data_types_result_acc
//
// Collects (c, d) result pairs from the data_types stage over a valid/ready
// handshake and sums each stream over a block of BLOCK_LEN samples. When the
// block is complete the two saturating sums, the sample count and a sticky
// overflow flag are presented over a second valid/ready handshake and held
// stable until the consumer takes them.
//
// Parameters:
//   OUTPUT_WIDTH  width of c_in/d_in (matches data_types output width)
//   ACC_WIDTH     accumulator width, must be >= OUTPUT_WIDTH
//   BLOCK_LEN     samples per block, must be >= 1
//
// Ports:
//   clk        single clock, rising-edge
//   rst_n      asynchronous active-low reset
//   clear      synchronous abort of the current block (highest priority)
//   in_valid   c_in/d_in carry a sample
//   in_ready   block can accept a sample (ACCUM state)
//   c_in/d_in  unsigned sample values
//   out_valid  block sums are presented (HOLD state)
//   out_ready  consumer takes the sums
//   sum_c      saturating sum of c_in over the block
//   sum_d      saturating sum of d_in over the block
//   count      samples accepted in the current block
//   overflow   sticky, set if either sum saturated in this block

module data_types_result_acc #(
    parameter int OUTPUT_WIDTH = 8,
    parameter int ACC_WIDTH    = 16,
    parameter int BLOCK_LEN    = 4,
    localparam int CNT_W       = $clog2(BLOCK_LEN + 1)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clear,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [OUTPUT_WIDTH-1:0] c_in,
    input  logic [OUTPUT_WIDTH-1:0] d_in,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [ACC_WIDTH-1:0]    sum_c,
    output logic [ACC_WIDTH-1:0]    sum_d,
    output logic [CNT_W-1:0]        count,
    output logic                    overflow
);

    localparam logic [0:0] ST_ACCUM = 1'b0;
    localparam logic [0:0] ST_HOLD  = 1'b1;

    localparam int EXT_W = ACC_WIDTH + 1 - OUTPUT_WIDTH;

    logic [0:0]           state;
    logic                 accept;
    logic                 last_sample;
    logic [ACC_WIDTH:0]   c_wide;
    logic [ACC_WIDTH:0]   d_wide;
    logic                 c_sat;
    logic                 d_sat;
    logic [ACC_WIDTH-1:0] c_next;
    logic [ACC_WIDTH-1:0] d_next;

    // Handshake flags come straight from the registered state so there is
    // no combinational path from in_valid or out_ready.
    assign in_ready  = (state == ST_ACCUM);
    assign out_valid = (state == ST_HOLD);

    assign accept      = in_valid && in_ready;
    assign last_sample = (count == CNT_W'(BLOCK_LEN - 1));

    // One extra bit of headroom: a carry into the top bit means the sum no
    // longer fits and is clamped to all-ones.
    always_comb begin
        c_wide = {1'b0, sum_c} + {{EXT_W{1'b0}}, c_in};
        d_wide = {1'b0, sum_d} + {{EXT_W{1'b0}}, d_in};
        c_sat  = c_wide[ACC_WIDTH];
        d_sat  = d_wide[ACC_WIDTH];
        c_next = c_sat ? {ACC_WIDTH{1'b1}} : c_wide[ACC_WIDTH-1:0];
        d_next = d_sat ? {ACC_WIDTH{1'b1}} : d_wide[ACC_WIDTH-1:0];
    end

    // clear outranks both the input accept and the output handshake; the
    // output handshake also starts the next block from zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_ACCUM;
            sum_c    <= '0;
            sum_d    <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else if (clear) begin
            state    <= ST_ACCUM;
            sum_c    <= '0;
            sum_d    <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            case (state)
                ST_ACCUM: begin
                    if (accept) begin
                        sum_c    <= c_next;
                        sum_d    <= d_next;
                        count    <= count + CNT_W'(1);
                        overflow <= overflow | c_sat | d_sat;
                        if (last_sample) begin
                            state <= ST_HOLD;
                        end
                    end
                end
                default: begin
                    if (out_ready) begin
                        state    <= ST_ACCUM;
                        sum_c    <= '0;
                        sum_d    <= '0;
                        count    <= '0;
                        overflow <= 1'b0;
                    end
                end
            endcase
        end
    end

endmodule
